// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one op in flight.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish one cycle after accept.
`timescale 1ns/1ps
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_result
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

   state_t           state;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic             q_neg;
   logic             r_neg;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] diff;
   logic             unused_diff_bit;

   function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
      logic signed [WIDTH-1:0] n;
      n = -v;
      return v[WIDTH-1] ? n : v;
   endfunction

   // op[0]==0 selects the signed variants (DIV/REM).
   function automatic logic is_special(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                       input logic [WIDTH-1:0] y);
      return (y == '0) || (!o[0] && (x == MIN_NEG) && (y == '1));
   endfunction

   function automatic logic [WIDTH-1:0] special_result(input logic [1:0] o,
                                                       input logic [WIDTH-1:0] x,
                                                       input logic [WIDTH-1:0] y);
      if (y == '0)
         return o[1] ? x : '1;
      return o[1] ? '0 : MIN_NEG;
   endfunction

   function automatic logic [WIDTH-1:0] signed_result(input logic [1:0] o,
                                                      input logic [WIDTH-1:0] q,
                                                      input logic [WIDTH-1:0] r,
                                                      input logic qn, input logic rn);
      logic [WIDTH-1:0] qf;
      logic [WIDTH-1:0] rf;
      qf = qn ? (~q + 1'b1) : q;
      rf = rn ? (~r + 1'b1) : r;
      return o[1] ? rf : qf;
   endfunction

   assign in_ready = (state == IDLE) && !rst;
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready && !flush;

   // Trial subtraction one bit wider than the shifted remainder; the top bit is the borrow.
   assign rem_sh          = {rem, quo[WIDTH-1]};
   assign diff            = {1'b0, rem_sh} - {2'b00, dvs};
   assign unused_diff_bit = diff[WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         out_valid  <= 1'b0;
         out_result <= '0;
      end else begin
         out_valid <= 1'b0;
         if (flush) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (accept) begin
`ifdef DIV_EARLY_OUT_EN
                     if (is_special(op, a, b)) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= special_result(op, a, b);
                     end else begin
                        state <= PREP;
                     end
`else
                     state <= PREP;
`endif
                  end
               end
               PREP: state <= CALC;
               CALC: begin
                  if (cnt == CNT_W'(WIDTH - 1))
                     state <= FIX;
               end
               FIX: begin
                  state      <= DONE;
                  out_valid  <= 1'b1;
                  out_result <= is_special(op_r, a_r, b_r) ? special_result(op_r, a_r, b_r)
                                                           : signed_result(op_r, quo, rem, q_neg, r_neg);
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Datapath registers carry no reset; the FSM qualifies every use of them.
   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (accept) begin
               op_r <= op;
               a_r  <= a;
               b_r  <= b;
            end
         end
         PREP: begin
            if (!op_r[0]) begin
               quo   <= abs_val($signed(a_r));
               dvs   <= abs_val($signed(b_r));
               q_neg <= a_r[WIDTH-1] ^ b_r[WIDTH-1];
               r_neg <= a_r[WIDTH-1];
            end else begin
               quo   <= a_r;
               dvs   <= b_r;
               q_neg <= 1'b0;
               r_neg <= 1'b0;
            end
            rem <= '0;
            cnt <= '0;
         end
         CALC: begin
            cnt <= cnt + 1'b1;
            if (!diff[WIDTH+1]) begin
               rem <= diff[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
               rem <= rem_sh[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], 1'b0};
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic model scoreboard plus hand-computed literal results.
`timescale 1ns/1ps
module tb_div_unit;
   localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
   localparam int SP_LAT = 1;
`else
   localparam int SP_LAT = 35;
`endif
   localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         flush;
   logic         busy;
   logic         out_valid;
   logic [W-1:0] out_result;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   div_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .flush(flush), .busy(busy), .out_valid(out_valid),
      .out_result(out_result)
   );

   // RISC-V M-extension semantics from plain arithmetic.
   function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
      logic signed [W-1:0] sx;
      logic signed [W-1:0] sy;
      sx = x;
      sy = y;
      if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
      if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
      case (o)
         DIV:     return sx / sy;
         DIVU:    return x / y;
         REM:     return sx % sy;
         default: return x % y;
      endcase
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got result %h expected no output", out_result);
         end else begin
            chk("model_result", out_result, exp_q.pop_front());
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (in_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got in_ready %b expected 1", in_ready);
      end
   endtask

   task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] lit, input int lat_exp);
      int lat;
      wait_ready();
      op = o; a = x; b = y; in_valid = 1'b1;
      exp_q.push_back(model(o, x, y));
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_latency"}, 32'(lat), 32'(lat_exp));
      chk(name, out_result, lit);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_ov;
      int accepts;
      int n;
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready_low", 32'(in_ready), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_result", out_result, 32'h0);
      rst = 1'b0;
      #1;
      chk("reset_in_ready_high", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      do_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 35);
      do_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 35);
      do_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
      do_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
      do_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35);
      do_op("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 35);
      do_op("div_m100_m7", DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 35);
      do_op("rem_m100_m7", REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 35);
      do_op("divu_big_3", DIVU, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 35);
      do_op("remu_big_3", REMU, 32'h8000_0000, 32'd3, 32'd2, 35);
      do_op("div_overflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SP_LAT);
      do_op("rem_overflow", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SP_LAT);
      do_op("div_by_zero", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SP_LAT);
      do_op("rem_by_zero", REM, 32'd5, 32'd0, 32'd5, SP_LAT);
      do_op("remu_by_zero", REMU, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, SP_LAT);
      do_op("divu_by_zero", DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, SP_LAT);
      do_op("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 35);

      // Flush in the tenth CALC cycle: nothing may come out.
      wait_ready();
      op = DIVU; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      chk("flush_busy", 32'(busy), 32'd0);
      n_ov = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) n_ov++;
      end
      chk("flush_no_output", 32'(n_ov), 32'd0);
      do_op("divu_9_3_after_flush", DIVU, 32'd9, 32'd3, 32'd3, 35);

      // Flush and request together in IDLE: request is dropped.
      wait_ready();
      op = DIVU; a = 32'd8; b = 32'd2; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_vs_valid_busy", 32'(busy), 32'd0);
      n_ov = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) n_ov++;
      end
      chk("flush_vs_valid_no_output", 32'(n_ov), 32'd0);

      // in_valid held high for the whole operation: exactly one accept.
      wait_ready();
      op = DIVU; a = 32'd50; b = 32'd5; in_valid = 1'b1;
      exp_q.push_back(model(DIVU, 32'd50, 32'd5));
      accepts = 0;
      n = 0;
      do begin
         @(negedge clk);
         if (in_valid && in_ready) accepts++;
         @(posedge clk); #1;
         n++;
      end while (out_valid !== 1'b1 && n < 100);
      in_valid = 1'b0;
      chk("held_valid_accepts", 32'(accepts), 32'd1);
      chk("held_valid_result", out_result, 32'd10);

      // Reset in the middle of CALC.
      wait_ready();
      op = DIVU; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_result", out_result, 32'h0);
      rst = 1'b0;
      n_ov = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) n_ov++;
      end
      chk("midrst_no_output", 32'(n_ov), 32'd0);
      do_op("divu_after_rst", DIVU, 32'd1000, 32'd3, 32'd333, 35);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
